uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between two byte producers: the DMA loader echo path and the memory-controller hub output path.
- Replaces the bare OR of the two start strobes and the mux of their data buses.
- Each requester pushes bytes into its own small FIFO through a valid/ready handshake.
- A round-robin scheduler drains the FIFOs one frame at a time, pacing itself on the transmitter's busy flag.

---
 rtl/uart_arb_pkg.sv | 16 +
 rtl/uart_tx_arbiter_byte_fifo.sv | 54 +++++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: scheduler states, requester ids and the byte type.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic REQ0_DMA = 1'b0;
    localparam logic REQ1_MCH = 1'b1;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/uart_tx_arbiter_byte_fifo.sv
// Per-requester byte FIFO; write lands at the head one cycle after the push edge, head read combinationally.
// Backpressure: o_full is a registered count decode and never anticipates a same-cycle pop.
module byte_fifo
    import uart_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       i_clock,
    input  logic       i_resetn,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);

    byte_t          r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == (AW + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between DMA (req 0) and MCH (req 1); push edge to start pulse is 2 edges.
// Requesters are backpressured by their own FIFO; UART_TX_ARB_LOCK_EN adds per-requester lock inputs.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic       i_clock,
    input  logic       i_resetn,
    input  logic       i_s0_valid,
    input  logic [7:0] i_s0_data,
    output logic       o_s0_ready,
    input  logic       i_s1_valid,
    input  logic [7:0] i_s1_data,
    output logic       o_s1_ready,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic       i_s0_lock,
    input  logic       i_s1_lock,
`endif
    input  logic       i_tx_busy,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_grant_id,
    output logic       o_idle
);

    localparam int              TW         = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [TW-1:0] r_timer;
    byte_t         r_tx_data;
    logic          r_grant_id;
    logic          r_last_grant;

    logic          w_full0, w_empty0, w_full1, w_empty1;
    byte_t         w_head0, w_head1;
    logic          w_pop0, w_pop1;
    logic          w_elig0, w_elig1;
    logic          w_take;
    logic          w_sel;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .i_clock  (i_clock),
        .i_resetn (i_resetn),
        .i_push   (i_s0_valid),
        .i_din    (i_s0_data),
        .i_pop    (w_pop0),
        .o_dout   (w_head0),
        .o_full   (w_full0),
        .o_empty  (w_empty0)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .i_clock  (i_clock),
        .i_resetn (i_resetn),
        .i_push   (i_s1_valid),
        .i_din    (i_s1_data),
        .i_pop    (w_pop1),
        .o_dout   (w_head1),
        .o_full   (w_full1),
        .o_empty  (w_empty1)
    );

`ifdef UART_TX_ARB_LOCK_EN
    logic r_any_grant;
    logic w_lock_hold;

    // A lock only pins the requester that already owns the UART.
    assign w_lock_hold = r_any_grant &
                         ((r_last_grant == REQ1_MCH) ? i_s1_lock : i_s0_lock);
    assign w_elig0 = ~w_empty0 & ~(w_lock_hold & (r_last_grant == REQ1_MCH));
    assign w_elig1 = ~w_empty1 & ~(w_lock_hold & (r_last_grant == REQ0_DMA));

    always_ff @(posedge i_clock) begin
        if (!i_resetn) r_any_grant <= 1'b0;
        else if (w_take) r_any_grant <= 1'b1;
    end
`else
    assign w_elig0 = ~w_empty0;
    assign w_elig1 = ~w_empty1;
`endif

    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_sel        = r_last_grant;
        case (r_state)
            IDLE: begin
                if (!i_tx_busy) begin
                    if (w_elig0 && w_elig1) begin
                        w_take = 1'b1;
                        w_sel  = ~r_last_grant;
                    end else if (w_elig0) begin
                        w_take = 1'b1;
                        w_sel  = REQ0_DMA;
                    end else if (w_elig1) begin
                        w_take = 1'b1;
                        w_sel  = REQ1_MCH;
                    end
                    if (w_take) w_next_state = START;
                end
            end
            START:     w_next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                // No busy response in time: the frame is dropped, not retried.
                if (i_tx_busy)                  w_next_state = WAIT_DONE;
                else if (r_timer == TIMER_LAST) w_next_state = IDLE;
            end
            WAIT_DONE: if (!i_tx_busy) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    assign w_pop0 = w_take & (w_sel == REQ0_DMA);
    assign w_pop1 = w_take & (w_sel == REQ1_MCH);

    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_tx_data    <= '0;
            r_grant_id   <= REQ0_DMA;
            r_last_grant <= REQ1_MCH;
        end else begin
            r_state <= w_next_state;
            if (w_take) begin
                r_tx_data    <= (w_sel == REQ1_MCH) ? w_head1 : w_head0;
                r_grant_id   <= w_sel;
                r_last_grant <= w_sel;
            end
            if (r_state == START)
                r_timer <= '0;
            else if (r_state == WAIT_BUSY && !i_tx_busy)
                r_timer <= r_timer + 1'b1;
        end
    end

    assign o_s0_ready = ~w_full0;
    assign o_s1_ready = ~w_full1;
    assign o_tx_start = (r_state == START);
    assign o_tx_data  = r_tx_data;
    assign o_grant_id = r_grant_id;
    assign o_idle     = (r_state == IDLE) & w_empty0 & w_empty1;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of single-byte frames plus hand-written multi-cycle sequences.
module tb_uart_tx_arbiter;

    logic       clock = 1'b0;
    logic       resetn;
    logic       s0_valid, s1_valid;
    logic [7:0] s0_data, s1_data;
    logic       s0_ready, s1_ready;
    logic       tx_busy, tx_start;
    logic [7:0] tx_data;
    logic       grant_id, idle;
`ifdef UART_TX_ARB_LOCK_EN
    logic       s0_lock, s1_lock;
`endif

    always #5 clock = ~clock;

    uart_tx_arbiter #(.DEPTH(4), .BUSY_TIMEOUT(4)) dut (
        .i_clock    (clock),
        .i_resetn   (resetn),
        .i_s0_valid (s0_valid),
        .i_s0_data  (s0_data),
        .o_s0_ready (s0_ready),
        .i_s1_valid (s1_valid),
        .i_s1_data  (s1_data),
        .o_s1_ready (s1_ready),
`ifdef UART_TX_ARB_LOCK_EN
        .i_s0_lock  (s0_lock),
        .i_s1_lock  (s1_lock),
`endif
        .i_tx_busy  (tx_busy),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .o_grant_id (grant_id),
        .o_idle     (idle)
    );

    // Transmitter model: busy rises on the edge that samples the start pulse and lasts busy_len cycles.
    logic       busy_force = 1'b0;
    logic       busy_auto  = 1'b0;
    int         busy_len   = 20;
    int         busy_ctr   = 0;
    int         cyc        = 0;
    int         start_cyc  = 0;
    int         n_starts   = 0;
    logic [7:0] log_data[$];
    logic       log_grant[$];

    assign tx_busy = busy_force | (busy_ctr != 0);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (tx_start) begin
            log_data.push_back(tx_data);
            log_grant.push_back(grant_id);
            start_cyc <= cyc;
            n_starts  <= n_starts + 1;
        end
        if (tx_start && busy_auto) busy_ctr <= busy_len;
        else if (busy_ctr > 0)     busy_ctr <= busy_ctr - 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name, input int idx, input logic g, input logic [7:0] d);
        logic [31:0] act;
        act = (log_data.size() > idx) ? {23'd0, log_grant[idx], log_data[idx]} : 32'hdead_0000;
        check(name, act, {23'd0, g, d});
    endtask

    task automatic wait_starts(input int target, input string name);
        for (int k = 0; k < 400 && n_starts < target; k++) @(negedge clock);
        check(name, 32'(n_starts >= target), 32'd1);
    endtask

    task automatic push_byte(input logic req, input logic [7:0] d, output int pcyc);
        int k;
        for (k = 0; k < 200 && !(req ? s1_ready : s0_ready); k++) @(negedge clock);
        if (k == 200) check("push ready timeout", 32'd0, 32'd1);
        if (req) begin s1_valid = 1'b1; s1_data = d; end
        else     begin s0_valid = 1'b1; s0_data = d; end
        pcyc = cyc;
        @(negedge clock);
        s0_valid = 1'b0;
        s1_valid = 1'b0;
    endtask

    task automatic reset_dut();
        busy_force = 1'b0;
        s0_valid   = 1'b0;
        s1_valid   = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        s0_lock    = 1'b0;
        s1_lock    = 1'b0;
`endif
        for (int k = 0; k < 200 && tx_busy; k++) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    typedef struct {
        logic       req;
        logic [7:0] data;
        int         blen;
        logic       exp_grant;
        logic [7:0] exp_data;
        int         exp_lat;   // edges from the push edge to the edge that samples tx_start
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pc, pc2, n0, base, s_first, acc;
        logic [7:0] exp_order[6];
        logic       exp_gr[6];

        vecs[0] = '{1'b0, 8'h41, 20, 1'b0, 8'h41, 2};
        vecs[1] = '{1'b1, 8'h7e,  6, 1'b1, 8'h7e, 2};
        vecs[2] = '{1'b0, 8'h00,  4, 1'b0, 8'h00, 2};
        vecs[3] = '{1'b1, 8'hff,  3, 1'b1, 8'hff, 2};

        resetn   = 1'b0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        s0_data  = 8'h00;
        s1_data  = 8'h00;
`ifdef UART_TX_ARB_LOCK_EN
        s0_lock  = 1'b0;
        s1_lock  = 1'b0;
`endif
        @(negedge clock);
        @(negedge clock);
        reset_dut();

        check("reset tx_start", 32'(tx_start), 32'd0);
        check("reset tx_data",  32'(tx_data),  32'd0);
        check("reset grant_id", 32'(grant_id), 32'd0);
        check("reset idle",     32'(idle),     32'd1);
        check("reset s0_ready", 32'(s0_ready), 32'd1);
        check("reset s1_ready", 32'(s1_ready), 32'd1);

        // Single-byte frames from the table.
        for (int v = 0; v < 4; v++) begin
            busy_auto = 1'b1;
            busy_len  = vecs[v].blen;
            n0   = n_starts;
            base = log_data.size();
            push_byte(vecs[v].req, vecs[v].data, pc);
            wait_starts(n0 + 1, "vec start seen");
            check("vec latency", 32'(start_cyc - pc), 32'(vecs[v].exp_lat));
            check_log("vec frame", base, vecs[v].exp_grant, vecs[v].exp_data);
            check("vec grant_id", 32'(grant_id), 32'(vecs[v].exp_grant));
            for (int k = 0; k < 100 && tx_busy; k++) @(negedge clock);
            check("vec tx_data held", 32'(tx_data), 32'(vecs[v].exp_data));
            check("vec idle low in WAIT_DONE", 32'(idle), 32'd0);
            @(negedge clock);
            check("vec idle after busy falls", 32'(idle), 32'd1);
            check("vec single start", 32'(n_starts), 32'(n0 + 1));
        end

        // Both FIFOs preloaded while the transmitter is held busy: strict alternation, s0 first.
        reset_dut();
        busy_force = 1'b1;
        busy_auto  = 1'b1;
        busy_len   = 5;
        n0   = n_starts;
        base = log_data.size();
        for (int i = 0; i < 3; i++) push_byte(1'b0, 8'h10 + 8'(i), pc);
        for (int i = 0; i < 3; i++) push_byte(1'b1, 8'h20 + 8'(i), pc);
        check("preload no start while busy", 32'(n_starts), 32'(n0));
        busy_force = 1'b0;
        wait_starts(n0 + 6, "preload starts");
        exp_order = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
        exp_gr    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) check_log("preload order", base + i, exp_gr[i], exp_order[i]);

        // Fill s1 to DEPTH behind a busy transmitter; the fifth byte stalls until a pop.
        reset_dut();
        busy_force = 1'b1;
        busy_auto  = 1'b1;
        busy_len   = 4;
        n0   = n_starts;
        base = log_data.size();
        for (int i = 0; i < 4; i++) begin
            check("full s1_ready before push", 32'(s1_ready), 32'd1);
            s1_valid = 1'b1;
            s1_data  = 8'h30 + 8'(i);
            @(negedge clock);
        end
        check("full s1_ready after 4 pushes", 32'(s1_ready), 32'd0);
        s1_data = 8'h34;
        repeat (3) @(negedge clock);
        check("full s1_ready stays low", 32'(s1_ready), 32'd0);
        busy_force = 1'b0;
        acc = 0;
        for (int k = 0; k < 100 && acc == 0; k++) begin
            if (s1_ready) acc = 1;
            @(negedge clock);
        end
        s1_valid = 1'b0;
        check("full fifth byte accepted", 32'(acc), 32'd1);
        wait_starts(n0 + 5, "full starts");
        for (int i = 0; i < 5; i++) check_log("full order", base + i, 1'b1, 8'h30 + 8'(i));

        // No busy response: one start, four WAIT_BUSY cycles, back to IDLE, next byte started.
        reset_dut();
        busy_auto = 1'b0;
        n0   = n_starts;
        base = log_data.size();
        push_byte(1'b0, 8'h51, pc);
        push_byte(1'b0, 8'h52, pc2);
        wait_starts(n0 + 1, "timeout first start");
        s_first = start_cyc;
        wait_starts(n0 + 2, "timeout second start");
        check("timeout start spacing", 32'(start_cyc - s_first), 32'd6);
        check_log("timeout frame 0", base,     1'b0, 8'h51);
        check_log("timeout frame 1", base + 1, 1'b0, 8'h52);
        repeat (20) @(negedge clock);
        check("timeout no retry", 32'(n_starts), 32'(n0 + 2));
        check("timeout idle", 32'(idle), 32'd1);

        // Reset in WAIT_DONE with two bytes queued.
        reset_dut();
        busy_auto = 1'b1;
        busy_len  = 20;
        n0 = n_starts;
        push_byte(1'b0, 8'h61, pc);
        wait_starts(n0 + 1, "midreset start");
        push_byte(1'b0, 8'h62, pc);
        push_byte(1'b1, 8'h63, pc);
        repeat (2) @(negedge clock);
        check("midreset busy before reset", 32'(idle), 32'd0);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check("midreset tx_start", 32'(tx_start), 32'd0);
        check("midreset tx_data",  32'(tx_data),  32'd0);
        check("midreset s0_ready", 32'(s0_ready), 32'd1);
        check("midreset s1_ready", 32'(s1_ready), 32'd1);
        check("midreset idle",     32'(idle),     32'd1);
        repeat (60) @(negedge clock);
        check("midreset no further start", 32'(n_starts), 32'(n0 + 1));
        check("midreset idle later", 32'(idle), 32'd1);

`ifdef UART_TX_ARB_LOCK_EN
        // s0 holds its lock across sparse bytes while s1 stays pending.
        reset_dut();
        busy_auto = 1'b1;
        busy_len  = 20;
        s0_lock   = 1'b1;
        n0   = n_starts;
        base = log_data.size();
        push_byte(1'b0, 8'ha0, pc);
        for (int i = 0; i < 3; i++) push_byte(1'b1, 8'hb0 + 8'(i), pc);
        for (int i = 1; i < 4; i++) begin
            repeat (29) @(negedge clock);
            push_byte(1'b0, 8'ha0 + 8'(i), pc);
        end
        wait_starts(n0 + 4, "lock four starts");
        s0_lock = 1'b0;
        wait_starts(n0 + 5, "lock s1 start");
        for (int i = 0; i < 4; i++) check_log("lock s0 burst", base + i, 1'b0, 8'ha0 + 8'(i));
        check_log("lock s1 after release", base + 4, 1'b1, 8'hb0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
